// File: rtl/router_pkt_tx_pkg.sv
`default_nettype none
// router_pkg: shared types and constants for the router packet transmitter.
// Rev 1.0
package router_pkg;

  localparam int ADDR_W  = 2;
  localparam int LEN_W   = 6;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 63;
  localparam int BUF_AW  = 6;
  localparam int BUF_DEPTH = 1 << BUF_AW;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HDR  = 3'd2,
    PAY  = 3'd3,
    PAR  = 3'd4,
    GAP  = 3'd5
  } state_e;

  function automatic logic [DATA_W-1:0] mk_header(input logic [LEN_W-1:0]  len,
                                                  input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_tx_if.sv
`default_nettype none
// router_pkt_tx_if: host command/payload stream plus router-side data/pkt_valid link.
// Rev 1.0
interface router_pkt_tx_if;
  import router_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_bad_par;
  logic              pay_valid;
  logic              pay_ready;
  logic [DATA_W-1:0] pay_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_pkt_valid;
  logic              rtr_busy;
  logic              rtr_err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_bad_par,
    input  pay_valid, pay_data, rtr_busy, rtr_err,
    output cmd_ready, pay_ready, tx_data, tx_pkt_valid
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_bad_par,
    output pay_valid, pay_data, rtr_busy, rtr_err,
    input  cmd_ready, pay_ready, tx_data, tx_pkt_valid
  );

endinterface
`default_nettype wire

// File: rtl/router_pkt_tx_buf.sv
`default_nettype none
// router_pkt_buf: 64x8 payload buffer with write index and read pointer.
// Rev 1.0
module router_pkt_buf
  import router_pkg::*;
(
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  input  wire logic              wr_clr_i,
  input  wire logic              wr_en_i,
  input  wire logic [DATA_W-1:0] wr_data_i,
  input  wire logic              rd_clr_i,
  input  wire logic              rd_inc_i,
  output logic      [BUF_AW-1:0] wr_idx_o,
  output logic      [BUF_AW-1:0] rd_ptr_o,
  output logic      [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [BUF_AW-1:0] wr_idx_q;
  logic [BUF_AW-1:0] rd_ptr_q;
  logic [BUF_AW-1:0] rd_ptr_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (rd_clr_i)      rd_ptr_d = '0;
    else if (rd_inc_i) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_idx_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_clr_i)     wr_idx_q <= '0;
      else if (wr_en_i) wr_idx_q <= wr_idx_q + 1'b1;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_q] <= wr_data_i;
  end

  // Read at the next pointer so the registered tx_data already holds the right byte.
  assign rd_data_o = mem_q[rd_ptr_d];
  assign wr_idx_o  = wr_idx_q;
  assign rd_ptr_o  = rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// router_pkt_tx: buffers a command + payload, then sends header/payload/parity to the router.
// Rev 1.0
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
)(
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  router_pkt_tx_if.master bus,
  output logic [CNT_W-1:0] pkt_sent_cnt_o,
  output logic [CNT_W-1:0] cmd_rej_cnt_o,
  output logic [CNT_W-1:0] rtr_err_cnt_o
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              bad_q, bad_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              pay_ready_q, pay_ready_d;
  logic              rtr_err_q;
  logic [CNT_W-1:0]  sent_cnt_q, rej_cnt_q, err_cnt_q;

  logic              rej_inc, sent_inc;
  logic              wr_clr, wr_en, rd_clr, rd_inc;
  logic [BUF_AW-1:0] wr_idx, rd_ptr;
  logic [DATA_W-1:0] rd_data;

  router_pkt_buf u_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_clr_i (wr_clr),
    .wr_en_i  (wr_en),
    .wr_data_i(bus.pay_data),
    .rd_clr_i (rd_clr),
    .rd_inc_i (rd_inc),
    .wr_idx_o (wr_idx),
    .rd_ptr_o (rd_ptr),
    .rd_data_o(rd_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    bad_d    = bad_q;
    parity_d = parity_q;
    gap_d    = gap_q;
    wr_clr   = 1'b0;
    wr_en    = 1'b0;
    rd_clr   = 1'b0;
    rd_inc   = 1'b0;
    rej_inc  = 1'b0;
    sent_inc = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid && cmd_ready_q) begin
        if (bus.cmd_addr == INVALID_ADDR || bus.cmd_len == '0) begin
          rej_inc = 1'b1;
        end else begin
          addr_d   = bus.cmd_addr;
          len_d    = bus.cmd_len;
          bad_d    = bus.cmd_bad_par;
          parity_d = mk_header(bus.cmd_len, bus.cmd_addr);
          wr_clr   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: if (bus.pay_valid && pay_ready_q) begin
        wr_en    = 1'b1;
        parity_d = parity_q ^ bus.pay_data;
        if (wr_idx == len_q - 1'b1) state_d = HDR;
      end
      HDR: if (!bus.rtr_busy) begin
        rd_clr  = 1'b1;
        state_d = PAY;
      end
      PAY: if (!bus.rtr_busy) begin
        rd_inc = 1'b1;
        if (rd_ptr == len_q - 1'b1) state_d = PAR;
      end
      PAR: if (!bus.rtr_busy) begin
        sent_inc = 1'b1;
        gap_d    = '0;
        state_d  = GAP;
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    cmd_ready_d = (state_d == IDLE);
    pay_ready_d = (state_d == LOAD);
    tx_valid_d  = (state_d == HDR) || (state_d == PAY);
    case (state_d)
      HDR:     tx_data_d = mk_header(len_d, addr_d);
      PAY:     tx_data_d = rd_data;
      PAR:     tx_data_d = parity_d ^ {DATA_W{bad_d}};
      default: tx_data_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      bad_q       <= 1'b0;
      parity_q    <= '0;
      gap_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      pay_ready_q <= 1'b0;
      rtr_err_q   <= 1'b0;
      sent_cnt_q  <= '0;
      rej_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      parity_q    <= parity_d;
      gap_q       <= gap_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      cmd_ready_q <= cmd_ready_d;
      pay_ready_q <= pay_ready_d;
      rtr_err_q   <= bus.rtr_err;
      if (sent_inc && sent_cnt_q != '1) sent_cnt_q <= sent_cnt_q + 1'b1;
      if (rej_inc && rej_cnt_q != '1)   rej_cnt_q  <= rej_cnt_q + 1'b1;
      if (bus.rtr_err && !rtr_err_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_pkt_valid = tx_valid_q;
  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.pay_ready    = pay_ready_q;
  assign pkt_sent_cnt_o   = sent_cnt_q;
  assign cmd_rej_cnt_o    = rej_cnt_q;
  assign rtr_err_cnt_o    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// tb_router_pkt_tx: directed self-checking bench for router_pkt_tx.
// Rev 1.0
module tb_router_pkt_tx;
  import router_pkg::*;

  typedef struct packed {
    logic       pr;
    logic       cr;
    logic       busy;
    logic       v;
    logic [7:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sent_cnt, rej_cnt, err_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pr_hi, v_hi;
  ent_t        log_q[$];
  logic [7:0]  pay_buf [64];

  always #5 clk = ~clk;

  router_pkt_tx_if ifc ();

  router_pkt_tx #(.GAP_CYCLES(2), .CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (ifc),
    .pkt_sent_cnt_o(sent_cnt),
    .cmd_rej_cnt_o (rej_cnt),
    .rtr_err_cnt_o (err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic bad);
    bit done = 1'b0;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b1; ifc.cmd_addr = a; ifc.cmd_len = l; ifc.cmd_bad_par = bad;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ifc.cmd_ready) begin @(posedge clk); #1; done = 1'b1; end
    end
    ifc.cmd_valid = 1'b0;
    if (!done) check_eq("cmd_timeout", 0, 1);
  endtask

  task automatic send_pay(input int len);
    for (int k = 0; k < len; k++) begin
      bit done = 1'b0;
      ifc.pay_valid = 1'b1; ifc.pay_data = pay_buf[k];
      for (int i = 0; i < 50 && !done; i++) begin
        @(negedge clk);
        if (ifc.pay_ready) begin @(posedge clk); #1; done = 1'b1; end
      end
      if (!done) begin check_eq("pay_timeout", 0, 1); break; end
    end
    ifc.pay_valid = 1'b0;
  endtask

  // Log every cycle from the header through three cycles past parity, stalling the
  // router for busy_n cycles starting at the first payload cycle.
  task automatic drain(input int busy_n);
    int hdr = -1;
    int par = -1;
    log_q.delete();
    for (int c = 0; c < 300; c++) begin
      ent_t e;
      @(negedge clk);
      e.pr = ifc.pay_ready; e.cr = ifc.cmd_ready; e.v = ifc.tx_pkt_valid; e.d = ifc.tx_data;
      if (hdr < 0 && e.v) hdr = c;
      if (hdr >= 0 && par < 0 && !e.v) par = c;
      ifc.rtr_busy = (hdr >= 0 && c > hdr && c <= hdr + busy_n);
      e.busy = ifc.rtr_busy;
      log_q.push_back(e);
      if (par >= 0 && c == par + 3) break;
    end
    ifc.rtr_busy = 1'b0;
  endtask

  task automatic check_pkt(input int len, input int busy_n, input logic [7:0] exp_hdr,
                           input logic [7:0] exp_par, input int exp_sent);
    int hdr = -1;
    int par = -1;
    int nfirst = 0;
    logic [7:0] xf[$];
    for (int i = 0; i < log_q.size(); i++) begin
      if (hdr < 0 && log_q[i].v) hdr = i;
      if (hdr >= 0 && par < 0 && !log_q[i].v) par = i;
    end
    if (hdr < 0 || par < 0 || log_q.size() <= par + 3) begin
      check_eq("pkt_seen", 0, 1);
      return;
    end
    check_eq("hdr_pay_ready", log_q[hdr].pr, 0);
    check_eq("hdr_cmd_ready", log_q[hdr].cr, 0);
    for (int i = hdr; i < par; i++) begin
      if (!log_q[i].busy) xf.push_back(log_q[i].d);
      if (i > hdr && log_q[i].d == pay_buf[0]) nfirst++;
    end
    check_eq("valid_cycles", par - hdr, len + 1 + busy_n);
    check_eq("first_byte_hold", nfirst, 1 + busy_n);
    check_eq("xfer_count", xf.size(), len + 1);
    if (xf.size() == len + 1) begin
      check_eq("header", xf[0], exp_hdr);
      for (int k = 0; k < len; k++) check_eq("pay_byte", xf[k+1], pay_buf[k]);
    end
    check_eq("parity", log_q[par].d, exp_par);
    check_eq("gap1_valid", log_q[par+1].v, 0);
    check_eq("gap1_data", log_q[par+1].d, 0);
    check_eq("gap2_data", log_q[par+2].d, 0);
    check_eq("gap_cmd_ready", log_q[par+2].cr, 0);
    check_eq("idle_cmd_ready", log_q[par+3].cr, 1);
    check_eq("sent_cnt", sent_cnt, exp_sent);
  endtask

  initial begin
    ifc.cmd_valid = 1'b0; ifc.cmd_addr = '0; ifc.cmd_len = '0; ifc.cmd_bad_par = 1'b0;
    ifc.pay_valid = 1'b0; ifc.pay_data = '0; ifc.rtr_busy = 1'b0; ifc.rtr_err = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", ifc.tx_pkt_valid, 0);
    check_eq("rst_data", ifc.tx_data, 0);
    check_eq("rst_cmd_ready", ifc.cmd_ready, 0);
    check_eq("rst_pay_ready", ifc.pay_ready, 0);
    check_eq("rst_sent", sent_cnt, 0);
    check_eq("rst_rej", rej_cnt, 0);
    check_eq("rst_err", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", ifc.cmd_ready, 1);

    // addr 1, len 3: header 0x0D; parity 0x0D^0x11^0x22^0x33 = 0x0D
    pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
    send_cmd(2'd1, 6'd3, 1'b0); send_pay(3); drain(0);
    check_pkt(3, 0, 8'h0D, 8'h0D, 1);

    // same packet, router busy for three cycles on the first payload byte
    send_cmd(2'd1, 6'd3, 1'b0); send_pay(3); drain(3);
    check_pkt(3, 3, 8'h0D, 8'h0D, 2);

    // invalid commands
    send_cmd(2'd3, 6'd5, 1'b0);
    @(negedge clk);
    check_eq("rej_stay_idle", ifc.cmd_ready, 1);
    send_cmd(2'd0, 6'd0, 1'b0);
    ifc.pay_valid = 1'b1;
    pr_hi = 0; v_hi = 0;
    repeat (6) begin
      @(negedge clk);
      pr_hi += int'(ifc.pay_ready);
      v_hi  += int'(ifc.tx_pkt_valid);
    end
    ifc.pay_valid = 1'b0;
    check_eq("rej_pay_ready", pr_hi, 0);
    check_eq("rej_valid", v_hi, 0);
    check_eq("rej_cnt", rej_cnt, 2);
    check_eq("rej_sent", sent_cnt, 2);

    // addr 2, len 63, payload 0..62: header 0xFE; parity 0xFE^0x3F = 0xC1
    for (int k = 0; k < 63; k++) pay_buf[k] = 8'(k);
    send_cmd(2'd2, 6'd63, 1'b0); send_pay(63); drain(0);
    check_pkt(63, 0, 8'hFE, 8'hC1, 3);

    // inverted parity: ~0x0D = 0xF2
    pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
    send_cmd(2'd1, 6'd3, 1'b1); send_pay(3); drain(0);
    check_pkt(3, 0, 8'h0D, 8'hF2, 4);

    check_eq("err_cnt_pre", err_cnt, 0);
    repeat (2) begin
      @(posedge clk); #1 ifc.rtr_err = 1'b1;
      @(posedge clk); #1 ifc.rtr_err = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("err_cnt", err_cnt, 2);

    // reset while payload is on the wire
    send_cmd(2'd1, 6'd3, 1'b0); send_pay(3);
    @(negedge clk);
    check_eq("pre_rst_hdr", ifc.tx_data, 8'h0D);
    @(negedge clk);
    check_eq("pre_rst_pay", ifc.tx_data, 8'h11);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", ifc.tx_pkt_valid, 0);
    check_eq("mid_rst_data", ifc.tx_data, 0);
    check_eq("mid_rst_cmd_ready", ifc.cmd_ready, 0);
    check_eq("mid_rst_sent", sent_cnt, 0);
    check_eq("mid_rst_rej", rej_cnt, 0);
    check_eq("mid_rst_err", err_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // addr 0, len 3: header 0x0C; payload XOR is 0x00 so parity 0x0C
    send_cmd(2'd0, 6'd3, 1'b0); send_pay(3); drain(0);
    check_pkt(3, 0, 8'h0C, 8'h0C, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
